// File: rtl/wb_copy_master_if.sv
// -----------------------------------------------------------------------------
// wb_copy_master_if
//
// Wishbone bus bundle between the copy master and a single RAM-style slave.
// Signal names keep the master-relative Wishbone suffixes:
//   STB_O  strobe              (master -> slave)
//   WE_O   write enable        (master -> slave)
//   ADR_O  word address        (master -> slave)
//   DAT_O  write data          (master -> slave)
//   DAT_I  read data           (slave  -> master), valid while ACK_I is high
//   ACK_I  acknowledge         (slave  -> master)
//
// Handshake: a transfer is accepted on the rising edge where STB_O and ACK_I
// are both high. The master holds ADR_O/WE_O/DAT_O stable for the whole time
// STB_O is high, and never looks at ACK_I while STB_O is low.
// -----------------------------------------------------------------------------
interface wb_copy_master_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) ();
    logic                     STB_O;
    logic                     WE_O;
    logic [ADDRESS_WIDTH-1:0] ADR_O;
    logic [DATA_WIDTH-1:0]    DAT_O;
    logic [DATA_WIDTH-1:0]    DAT_I;
    logic                     ACK_I;

    modport master (
        output STB_O,
        output WE_O,
        output ADR_O,
        output DAT_O,
        input  DAT_I,
        input  ACK_I
    );

    modport slave (
        input  STB_O,
        input  WE_O,
        input  ADR_O,
        input  DAT_O,
        output DAT_I,
        output ACK_I
    );
endinterface

// File: rtl/wb_copy_master.sv
// -----------------------------------------------------------------------------
// wb_copy_master
//
// Wishbone initiator that copies LEN words from a source address range to a
// destination address range, one read followed by one write per word.
//
// Ports:
//   CLK_I        clock, rising edge
//   RSTN_I       synchronous active-low reset
//   START_I      start request, only looked at in IDLE
//   SRC_I/DST_I  first source / destination address, latched on start
//   LEN_I        number of words, latched on start
//   BUSY_O       high while the FSM is not in IDLE
//   DONE_O       one-cycle pulse when a copy ends (normally or by timeout)
//   ERR_O        sticky timeout flag, cleared by the next accepted start
//   DBG_STATE_O  current FSM state encoding, for observation only
//   wb           Wishbone master bundle (STB/WE/ADR/DAT out, DAT/ACK in)
//
// Every output is a flop. The combinational process computes the next state
// together with the next value of each output flop, so outputs change on the
// same edge the state does.
//
// TIMEOUT must be at least 1.
// -----------------------------------------------------------------------------
module wb_copy_master #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int LEN_WIDTH     = 8,
    parameter int TIMEOUT       = 15
) (
    input  logic                     CLK_I,
    input  logic                     RSTN_I,
    input  logic                     START_I,
    input  logic [ADDRESS_WIDTH-1:0] SRC_I,
    input  logic [ADDRESS_WIDTH-1:0] DST_I,
    input  logic [LEN_WIDTH-1:0]     LEN_I,
    output logic                     BUSY_O,
    output logic                     DONE_O,
    output logic                     ERR_O,
    output logic [2:0]               DBG_STATE_O,
    wb_copy_master_if.master         wb
);

    // The wait counter only needs to reach TIMEOUT-1: the edge that would
    // take it to TIMEOUT is the abort edge itself.
    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_GAP = 3'd2,
        WR_REQ = 3'd3,
        WR_GAP = 3'd4
    } state_t;

    state_t                   state_q,  state_d;
    logic [ADDRESS_WIDTH-1:0] src_q,    src_d;
    logic [ADDRESS_WIDTH-1:0] dst_q,    dst_d;
    logic [LEN_WIDTH-1:0]     rem_q,    rem_d;
    logic [DATA_WIDTH-1:0]    buf_q,    buf_d;
    logic [WAIT_W-1:0]        wait_q,   wait_d;
    logic                     stb_q,    stb_d;
    logic                     we_q,     we_d;
    logic [ADDRESS_WIDTH-1:0] adr_q,    adr_d;
    logic [DATA_WIDTH-1:0]    dat_q,    dat_d;
    logic                     busy_q,   busy_d;
    logic                     done_q,   done_d;
    logic                     err_q,    err_d;

    always_ff @(posedge CLK_I) begin
        if (!RSTN_I) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            buf_q   <= '0;
            wait_q  <= '0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            buf_q   <= buf_d;
            wait_q  <= wait_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        wait_d  = wait_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (START_I) begin
                    src_d = SRC_I;
                    dst_d = DST_I;
                    rem_d = LEN_I;
                    err_d = 1'b0;
                    if (LEN_I == '0) begin
                        // Nothing to move: finish without leaving IDLE.
                        done_d = 1'b1;
                    end else begin
                        state_d = RD_REQ;
                        stb_d   = 1'b1;
                        we_d    = 1'b0;
                        adr_d   = SRC_I;
                        wait_d  = '0;
                    end
                end
            end

            RD_REQ: begin
                if (wb.ACK_I) begin
                    buf_d   = wb.DAT_I;
                    src_d   = src_q + 1'b1;
                    state_d = RD_GAP;
                    stb_d   = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            // The slave registers ACK from STB, so ACK is still high here
            // from the previous request; it is deliberately not examined.
            RD_GAP: begin
                state_d = WR_REQ;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                adr_d   = dst_q;
                dat_d   = buf_q;
                wait_d  = '0;
            end

            WR_REQ: begin
                if (wb.ACK_I) begin
                    dst_d   = dst_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                    state_d = WR_GAP;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = IDLE;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            WR_GAP: begin
                if (rem_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RD_REQ;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = src_q;
                    wait_d  = '0;
                end
            end

            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
                we_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign wb.STB_O    = stb_q;
    assign wb.WE_O     = we_q;
    assign wb.ADR_O    = adr_q;
    assign wb.DAT_O    = dat_q;
    assign BUSY_O      = busy_q;
    assign DONE_O      = done_q;
    assign ERR_O       = err_q;
    assign DBG_STATE_O = state_q;

endmodule
